x_bus_master: RTL

Command-driven master for the X side of the SIF bus. Accepts read/write commands over a valid/ready handshake and buffers them in a small FIFO. Executes each command as a single-cycle strobe on xa_addr/xa_data_wr/xa_wr_s/xa_rd_s, captures read data after a fixed latency and returns one response per command. It sits directly upstream of the X monitor and the X-side slave, and produces the traffic they observe.

---
 rtl/x_bus_pkg.sv | 21 ++
 rtl/x_bus_master_if.sv | 39 +++
 rtl/x_cmd_fifo.sv | 72 +++++++
 rtl/x_bus_master.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/x_bus_pkg.sv
// Shared types for the X-side SIF bus master: default widths, FSM states
// and the command word that travels through the command FIFO.
package x_bus_pkg;

  localparam int X_AW = 16;
  localparam int X_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } x_state_e;

  typedef struct packed {
    logic            wr;
    logic [X_AW-1:0] addr;
    logic [X_DW-1:0] wdata;
  } x_cmd_t;

endpackage

// File: rtl/x_bus_master_if.sv
// Command, response and X-bus signals of the bus master, bundled so that the
// master and whatever drives/observes it share one connection.
interface x_bus_master_if
  import x_bus_pkg::*;
#(
  parameter int AW = X_AW,
  parameter int DW = X_DW
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_wr;
  logic [DW-1:0] rsp_rdata;

  logic [AW-1:0] xa_addr;
  logic [DW-1:0] xa_data_wr;
  logic          xa_wr_s;
  logic          xa_rd_s;
  logic [DW-1:0] xa_data_rd;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, xa_data_rd,
    output cmd_ready, rsp_valid, rsp_wr, rsp_rdata,
    output xa_addr, xa_data_wr, xa_wr_s, xa_rd_s
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, xa_data_rd,
    input  cmd_ready, rsp_valid, rsp_wr, rsp_rdata,
    input  xa_addr, xa_data_wr, xa_wr_s, xa_rd_s
  );

endinterface

// File: rtl/x_cmd_fifo.sv
// Synchronous FIFO of bus commands. DEPTH must be a power of two so the
// read/write pointers wrap naturally; the level counter tells full from empty.
module x_cmd_fifo
  import x_bus_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  x_cmd_t        din,
  output x_cmd_t        dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  x_cmd_t        mem_q [DEPTH];
  x_cmd_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/x_bus_master.sv
// X-side SIF bus master: queues read/write commands, issues each as a
// one-cycle strobe and returns exactly one response per command, in order.
module x_bus_master
  import x_bus_pkg::*;
#(
  parameter  int AW         = X_AW,
  parameter  int DW         = X_DW,
  parameter  int FIFO_DEPTH = 4,
  parameter  int RD_LAT     = 2,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  x_bus_master_if.master bus,
  output logic          busy,
  output logic [LW-1:0] fifo_level
);

  localparam int CW = 4;

  x_state_e      state_q, state_d;
  x_cmd_t        cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] xa_addr_q, xa_addr_d;
  logic [DW-1:0] xa_data_wr_q, xa_data_wr_d;
  logic          xa_wr_s_q, xa_wr_s_d;
  logic          xa_rd_s_q, xa_rd_s_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_wr_q, rsp_wr_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          busy_q, busy_d;

  x_cmd_t        fifo_din;
  x_cmd_t        fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [LW-1:0] level_nxt;

  assign fifo_din   = '{wr:    bus.cmd_wr,
                        addr:  X_AW'(bus.cmd_addr),
                        wdata: X_DW'(bus.cmd_wdata)};
  assign fifo_push  = bus.cmd_valid && !fifo_full;
  assign fifo_pop   = (state_q == IDLE) && !fifo_empty;
  assign level_nxt  = fifo_level + LW'(fifo_push) - LW'(fifo_pop);

  x_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // The first RESP cycle (rsp_valid still low) is the read-data capture
  // cycle, which lands it RD_LAT cycles after the visible strobe.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    xa_addr_d    = xa_addr_q;
    xa_data_wr_d = xa_data_wr_q;
    xa_wr_s_d    = 1'b0;
    xa_rd_s_d    = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_wr_d     = rsp_wr_q;
    rsp_rdata_d  = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          cmd_d   = fifo_dout;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        xa_addr_d = AW'(cmd_q.addr);
        if (cmd_q.wr) begin
          xa_data_wr_d = DW'(cmd_q.wdata);
          xa_wr_s_d    = 1'b1;
          state_d      = RESP;
        end else begin
          xa_rd_s_d = 1'b1;
          cnt_d     = CW'(RD_LAT - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_wr_d    = cmd_q.wr;
          rsp_rdata_d = cmd_q.wr ? '0 : bus.xa_data_rd;
        end else if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || (level_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      cnt_q        <= '0;
      xa_addr_q    <= '0;
      xa_data_wr_q <= '0;
      xa_wr_s_q    <= 1'b0;
      xa_rd_s_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_wr_q     <= 1'b0;
      rsp_rdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      xa_addr_q    <= xa_addr_d;
      xa_data_wr_q <= xa_data_wr_d;
      xa_wr_s_q    <= xa_wr_s_d;
      xa_rd_s_q    <= xa_rd_s_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_wr_q     <= rsp_wr_d;
      rsp_rdata_q  <= rsp_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.cmd_ready  = !fifo_full;
  assign bus.xa_addr    = xa_addr_q;
  assign bus.xa_data_wr = xa_data_wr_q;
  assign bus.xa_wr_s    = xa_wr_s_q;
  assign bus.xa_rd_s    = xa_rd_s_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_wr     = rsp_wr_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign busy           = busy_q;

endmodule
